// File: rtl/shift_register_universal_n.sv
// Parametrised universal shift register with word framing.
// Hold / shift right / shift left / parallel load, serial taps at both ends
// so instances cascade, and a framing counter that pulses WORD_VALID each
// time WIDTH consecutive same-direction shifts have assembled a full word.
module shift_register_universal_n #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [1:0]                 MODE,
  input  logic                       SERIAL_IN_R,
  input  logic                       SERIAL_IN_L,
  input  logic [WIDTH-1:0]           PAR_IN,
  output logic [WIDTH-1:0]           OUT,
  output logic                       SERIAL_OUT_R,
  output logic                       SERIAL_OUT_L,
  output logic                       WORD_VALID,
  output logic [$clog2(WIDTH)-1:0]   BIT_COUNT
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Direction of the most recent shift; a change of direction mid-word
  // discards the partial word.
  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
    $error("shift_register_universal_n: WIDTH must be in 2..64");
  end

  mode_e            mode;
  logic [WIDTH-1:0] q, q_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             last_dir, dir_next;
  logic             word_valid, valid_next;

  assign mode = mode_e'(MODE);

  // Next register contents for the selected mode.
  always_comb begin
    q_next = q;
    case (mode)
      MODE_HOLD:  q_next = q;
      MODE_RIGHT: q_next = {SERIAL_IN_R, q[WIDTH-1:1]};
      MODE_LEFT:  q_next = {q[WIDTH-2:0], SERIAL_IN_L};
      MODE_LOAD:  q_next = PAR_IN;
      default:    q_next = q;
    endcase
  end

  // Framing counter: restart on direction change, wrap and pulse on a full word.
  always_comb begin
    cnt_next   = cnt;
    dir_next   = last_dir;
    valid_next = 1'b0;
    case (mode)
      MODE_RIGHT, MODE_LEFT: begin
        dir_next = (mode == MODE_LEFT) ? DIR_L : DIR_R;
        if (cnt != '0 && dir_next != last_dir) begin
          cnt_next = CNT_W'(1);
        end else if (cnt == LAST_BIT) begin
          cnt_next   = '0;
          valid_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      MODE_LOAD: cnt_next = '0;
      default:   cnt_next = cnt;
    endcase
  end

  // State update; reset overrides every mode.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q          <= RESET_VALUE;
      cnt        <= '0;
      last_dir   <= DIR_R;
      word_valid <= 1'b0;
    end else begin
      q          <= q_next;
      cnt        <= cnt_next;
      last_dir   <= dir_next;
      word_valid <= valid_next;
    end
  end

  assign OUT          = q;
  assign SERIAL_OUT_R = q[0];
  assign SERIAL_OUT_L = q[WIDTH-1];
  assign WORD_VALID   = word_valid;
  assign BIT_COUNT    = cnt;

endmodule

// File: tb/tb_shift_register_universal_n.sv
// Bench for shift_register_universal_n: a 4-bit and an 8-bit instance share
// one stimulus stream; a word-level model predicts both every cycle, and
// hand-computed literals pin the model on the listed scenarios.
module tb_shift_register_universal_n;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       sin_r, sin_l;
  logic [7:0] par_in;

  logic [3:0] out4;
  logic       sor4, sol4, wv4;
  logic [1:0] bc4;
  logic [7:0] out8;
  logic       sor8, sol8, wv8;
  logic [2:0] bc8;

  int errors = 0;
  int checks = 0;

  shift_register_universal_n #(.WIDTH(4), .RESET_VALUE(4'h0)) dut4 (
    .CLK(clk), .RST(rst), .MODE(mode), .SERIAL_IN_R(sin_r), .SERIAL_IN_L(sin_l),
    .PAR_IN(par_in[3:0]), .OUT(out4), .SERIAL_OUT_R(sor4), .SERIAL_OUT_L(sol4),
    .WORD_VALID(wv4), .BIT_COUNT(bc4)
  );

  shift_register_universal_n #(.WIDTH(8), .RESET_VALUE(8'h3C)) dut8 (
    .CLK(clk), .RST(rst), .MODE(mode), .SERIAL_IN_R(sin_r), .SERIAL_IN_L(sin_l),
    .PAR_IN(par_in), .OUT(out8), .SERIAL_OUT_R(sor8), .SERIAL_OUT_L(sol8),
    .WORD_VALID(wv8), .BIT_COUNT(bc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: register as plain arithmetic on a word, framing as "bits collected
  // into the current word". Index 0 is the 4-bit instance, 1 the 8-bit one.
  logic [7:0] m_q   [2];
  int         m_len [2];
  int         m_dir [2];   // 0 right, 1 left
  logic       m_vld [2];
  bit         m_ok = 1'b0;

  function automatic int wid(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int         w;
      logic [7:0] mask;
      int         d;
      w    = wid(k);
      mask = 8'((1 << w) - 1);
      if (rst) begin
        m_q[k]   = (k == 0) ? 8'h00 : 8'h3C;
        m_len[k] = 0;
        m_dir[k] = 0;
        m_vld[k] = 1'b0;
      end else begin
        m_vld[k] = 1'b0;
        d = -1;
        case (mode)
          2'b01: begin m_q[k] = ((m_q[k] >> 1) | (8'(sin_r) << (w - 1))) & mask; d = 0; end
          2'b10: begin m_q[k] = ((m_q[k] << 1) | 8'(sin_l)) & mask; d = 1; end
          2'b11: begin m_q[k] = par_in & mask; m_len[k] = 0; end
          default: ;
        endcase
        if (d >= 0) begin
          if (m_len[k] != 0 && d != m_dir[k]) begin
            m_len[k] = 1;
          end else begin
            m_len[k] = m_len[k] + 1;
            if (m_len[k] == w) begin
              m_len[k] = 0;
              m_vld[k] = 1'b1;
            end
          end
          m_dir[k] = d;
        end
      end
    end
    if (rst) m_ok = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("m4_out", 64'(out4), 64'(m_q[0][3:0]));
      chk("m4_sor", 64'(sor4), 64'(m_q[0][0]));
      chk("m4_sol", 64'(sol4), 64'(m_q[0][3]));
      chk("m4_wv",  64'(wv4),  64'(m_vld[0]));
      chk("m4_bc",  64'(bc4),  64'(m_len[0]));
      chk("m8_out", 64'(out8), 64'(m_q[1]));
      chk("m8_sor", 64'(sor8), 64'(m_q[1][0]));
      chk("m8_sol", 64'(sol8), 64'(m_q[1][7]));
      chk("m8_wv",  64'(wv8),  64'(m_vld[1]));
      chk("m8_bc",  64'(bc8),  64'(m_len[1]));
    end
  end

  task automatic step(input logic [1:0] m, input logic sr, input logic sl,
                      input logic [7:0] p, input logic r);
    mode   = m;
    sin_r  = sr;
    sin_l  = sl;
    par_in = p;
    rst    = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] t1_bits;
    logic [3:0] t1_bc [4];
    logic [3:0] t2_out [4];
    logic [3:0] t2_bits;
    logic [7:0] pat;

    t1_bits = 4'b1101;   // applied LSB first: 1,0,1,1
    t1_bc   = '{4'd1, 4'd2, 4'd3, 4'd0};
    t2_bits = 4'b0011;   // applied LSB first: 1,1,0,0
    t2_out  = '{4'b0001, 4'b0011, 4'b0110, 4'b1100};
    pat     = 8'hB2;

    mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; par_in = 8'h00; rst = 1'b1;
    step(2'b00, 1'b0, 1'b0, 8'h00, 1'b1);
    step(2'b00, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("rst_out4", 64'(out4), 64'h0);
    chk("rst_bc4",  64'(bc4),  64'h0);
    chk("rst_wv4",  64'(wv4),  64'h0);
    chk("rst_out8", 64'(out8), 64'h3C);
    chk("rst_sol8", 64'(sol8), 64'h0);

    // 1: right shifts 1,0,1,1
    for (int i = 0; i < 4; i++) begin
      step(2'b01, t1_bits[i], 1'b0, 8'h00, 1'b0);
      chk("t1_bc", 64'(bc4), 64'(t1_bc[i]));
      chk("t1_wv", 64'(wv4), (i == 3) ? 64'h1 : 64'h0);
    end
    chk("t1_out", 64'(out4), 64'hD);
    step(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1_wv_after", 64'(wv4), 64'h0);

    // 2: clear, then left shifts 1,1,0,0
    step(2'b11, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(2'b10, 1'b0, t2_bits[i], 8'h00, 1'b0);
      chk("t2_out", 64'(out4), 64'(t2_out[i]));
      chk("t2_wv", 64'(wv4), (i == 3) ? 64'h1 : 64'h0);
    end
    chk("t2_sol", 64'(sol4), 64'h1);

    // 3: load 1010 then shift out with zeros
    step(2'b11, 1'b0, 1'b0, 8'h0A, 1'b0);
    chk("t3_load_wv", 64'(wv4), 64'h0);
    chk("t3_sor0", 64'(sor4), 64'h0);
    step(2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t3_sor1", 64'(sor4), 64'h1);
    step(2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t3_sor2", 64'(sor4), 64'h0);
    step(2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t3_sor3", 64'(sor4), 64'h1);
    chk("t3_wv3",  64'(wv4),  64'h0);
    step(2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t3_out", 64'(out4), 64'h0);
    chk("t3_wv4", 64'(wv4),  64'h1);

    // 4: holds inside a word
    step(2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
    step(2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t4_bc2", 64'(bc4), 64'h2);
    step(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t4_hold_bc", 64'(bc4), 64'h2);
    step(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t4_hold_bc", 64'(bc4), 64'h2);
    chk("t4_hold_out", 64'(out4), 64'h4);
    step(2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("t4_wv3", 64'(wv4), 64'h0);
    step(2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("t4_wv4", 64'(wv4), 64'h1);
    chk("t4_bc0", 64'(bc4), 64'h0);

    // 5: direction change mid-word
    for (int i = 0; i < 3; i++) step(2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t5_bc3", 64'(bc4), 64'h3);
    step(2'b10, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("t5_restart_bc", 64'(bc4), 64'h1);
    chk("t5_restart_wv", 64'(wv4), 64'h0);
    step(2'b10, 1'b0, 1'b1, 8'h00, 1'b0);
    step(2'b10, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("t5_wv_pre", 64'(wv4), 64'h0);
    step(2'b10, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("t5_wv", 64'(wv4), 64'h1);
    chk("t5_out", 64'(out4), 64'hF);

    // 6: reset mid-word wins over load
    step(2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
    step(2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
    step(2'b11, 1'b0, 1'b0, 8'hFF, 1'b1);
    chk("t6_out4", 64'(out4), 64'h0);
    chk("t6_bc4",  64'(bc4),  64'h0);
    chk("t6_wv4",  64'(wv4),  64'h0);
    chk("t6_out8", 64'(out8), 64'h3C);
    chk("t6_bc8",  64'(bc8),  64'h0);

    // 6b: 8-bit word, pulse only after the eighth shift
    for (int i = 0; i < 8; i++) begin
      step(2'b01, pat[i], 1'b0, 8'h00, 1'b0);
      chk("t6b_wv8", 64'(wv8), (i == 7) ? 64'h1 : 64'h0);
      if (i == 6) chk("t6b_bc8", 64'(bc8), 64'h7);
    end
    chk("t6b_out8", 64'(out8), 64'hB2);
    chk("t6b_bc8_wrap", 64'(bc8), 64'h0);

    // Mixed traffic checked by the model only.
    for (int i = 0; i < 300; i++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 6) m = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      step(m, 1'($urandom), 1'($urandom), 8'($urandom),
           ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_register_universal_n.md
Name: shift_register_universal_n

Overview:
Parametrised universal shift register, WIDTH bits wide, the successor to the fixed 4-bit SIPO register.
- Modes: hold, shift right (serial-in at MSB), shift left (serial-in at LSB), parallel load.
- Serial outputs at both ends, so instances cascade.
- A word-framing counter pulses WORD_VALID each time WIDTH consecutive same-direction shifts complete a word.
- Used as a configurable SIPO/PISO/deserializer stage.

Parameters:
WIDTH, 4, register width in bits; legal range 2..64.
RESET_VALUE, 0, value loaded into the register on reset (WIDTH bits).

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
MODE  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
SERIAL_IN_R  input  1  bit entering q[WIDTH-1] on shift right
SERIAL_IN_L  input  1  bit entering q[0] on shift left
PAR_IN  input  WIDTH  data for parallel load
OUT  output  WIDTH  register contents q
SERIAL_OUT_R  output  1  q[0] (bit leaving on shift right)
SERIAL_OUT_L  output  1  q[WIDTH-1] (bit leaving on shift left)
WORD_VALID  output  1  one-cycle pulse: OUT holds a complete shifted-in word
BIT_COUNT  output  $clog2(WIDTH)  shifts accumulated toward the current word

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST. RST has priority over MODE.
- Reset state:
  - q = RESET_VALUE.
  - BIT_COUNT = 0.
  - WORD_VALID = 0.
  - Internal last_dir = right.
- Serial outputs are combinational from q, so they equal RESET_VALUE bits after reset.
- Register update, on each rising edge with RST=0:
  - 00 hold: q unchanged.
  - 01 shift right: q[WIDTH-1] <= SERIAL_IN_R; q[i] <= q[i+1] for i < WIDTH-1.
  - 10 shift left: q[0] <= SERIAL_IN_L; q[i] <= q[i-1] for i > 0.
  - 11 load: q <= PAR_IN.
  - Latency: OUT reflects the operation one cycle after the edge. No combinational path from inputs to OUT.
- Framing counter, on a shift (modes 01/10) in direction d:
  - If BIT_COUNT != 0 and d != last_dir: BIT_COUNT <= 1. The partial word is discarded and this shift starts a new word. No pulse.
  - Else if BIT_COUNT == WIDTH-1: BIT_COUNT <= 0 (wrap) and WORD_VALID <= 1.
  - Else: BIT_COUNT <= BIT_COUNT+1.
  - Every shift sets last_dir <= d.
- Framing counter in the other modes:
  - Hold: BIT_COUNT and last_dir unchanged.
  - Load: BIT_COUNT <= 0. A load never asserts WORD_VALID.
- WORD_VALID:
  - Registered. Defaults to 0 every cycle unless set by the wrap rule.
  - High for exactly the one cycle in which OUT first shows the completed word.
  - Continuous shifting gives one pulse every WIDTH cycles.
- Hold cycles interleaved with shifts do not break a word; the count resumes.
- Reset mid-word: the partial word is lost. The first shift after reset counts as bit 1 in either direction.
- RST asserted in the same cycle as any MODE: the reset result only, and WORD_VALID = 0.

Test Plan:
1. WIDTH=4, reset, then MODE=01 with SERIAL_IN_R = 1,0,1,1 over 4 cycles -> OUT = 4'b1101. WORD_VALID=1 in that cycle only. BIT_COUNT = 1,2,3,0.
2. WIDTH=4, MODE=10 with SERIAL_IN_L = 1,1,0,0 -> OUT = 0001, 0011, 0110, 1100. WORD_VALID pulses with 1100. SERIAL_OUT_L = 1 at the end.
3. MODE=11, PAR_IN=4'b1010, then MODE=01 with SERIAL_IN_R=0 for 4 cycles -> SERIAL_OUT_R = 0,1,0,1 on successive cycles. OUT ends at 0000. One WORD_VALID pulse on the 4th shift.
4. Two right shifts, then two hold cycles, then two right shifts -> BIT_COUNT holds at 2 during hold. WORD_VALID fires on the 4th shift.
5. Three right shifts, then one left shift -> BIT_COUNT = 1, no WORD_VALID. Three more left shifts -> WORD_VALID pulse.
6. Two shifts, then RST=1 with MODE=11 and PAR_IN=4'b1111 -> OUT = RESET_VALUE, BIT_COUNT=0, WORD_VALID=0. Repeat the first test at WIDTH=8 with an 8-bit pattern: pulse after the 8th shift.
